// File: rtl/finalprojsoc_pio_pkg.sv
// Shared constants for the SoC parallel-I/O style slave ports.
// The keycode input port uses these definitions:
//   - ADDR_*  register offsets on the 2-bit Avalon-MM address
//   - EDGE_*  capture-edge selection codes for the EDGE_TYPE parameter
//   - PRIME_DONE  count at which edge capture becomes enabled after reset
package finalprojsoc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [1:0] PRIME_DONE = 2'd3;

endpackage

// File: rtl/finalprojsoc_sync2.sv
// Two-flop synchronizer for a bus of independent, asynchronous level inputs.
// Each bit is synchronized on its own; no coherency between bits is implied.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset, clears both stages
//   i_d      asynchronous input bus
//   o_q      synchronized output bus (two clocks of latency)
module finalprojsoc_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/finalprojsoc_keyin.sv
// Avalon-MM slave input port: external hardware drives a DATA_WIDTH-bit
// value which the CPU reads. Adds synchronization, per-bit sticky edge
// capture with write-1-to-clear, and a maskable level interrupt.
// Register map (read data zero-padded above DATA_WIDTH):
//   0  data_in       read-only
//   1  reads zero    writes ignored
//   2  irq_mask      read/write
//   3  edge_capture  read, write-1-to-clear per bit
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write/select interface
//   in_port               external input, asynchronous to clk
//   readdata              registered read data, one cycle latency
//   irq                   level interrupt, |(edge_capture & irq_mask)
module finalprojsoc_keyin
    import finalprojsoc_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    EDGE_TYPE  = EDGE_RISE,
    parameter logic [DATA_WIDTH-1:0] RESET_MASK = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] w_data_in;
    logic [DATA_WIDTH-1:0] r_d1;
    logic [1:0]            r_prime;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_edge;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_capture_en;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_edges;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_edge_next;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_wdata;

    finalprojsoc_sync2 #(
        .WIDTH (DATA_WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (in_port),
        .o_q     (w_data_in)
    );

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[DATA_WIDTH-1:0];
    // Bits above DATA_WIDTH are never stored.
    assign w_unused_wdata = ^writedata;

    // Capture stays off until the synchronizer and d1 hold real post-reset
    // samples, so an input already high at reset does not look like an edge.
    assign w_capture_en = (r_prime == PRIME_DONE);

    always_comb begin
        w_edges = '0;
        case (EDGE_TYPE)
            EDGE_FALL: w_edges = ~w_data_in & r_d1;
            EDGE_ANY:  w_edges = w_data_in ^ r_d1;
            default:   w_edges = w_data_in & ~r_d1;
        endcase
    end

    assign w_clr = (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;

    // Clear first, then OR in new edges: a detect coinciding with a
    // write-1-to-clear on the same bit leaves the bit set.
    assign w_edge_next = (r_edge & ~w_clr) | (w_capture_en ? w_edges : '0);

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux[DATA_WIDTH-1:0] = w_data_in;
            ADDR_DIR:  w_rd_mux = '0;
            ADDR_MASK: w_rd_mux[DATA_WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rd_mux[DATA_WIDTH-1:0] = r_edge;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1       <= '0;
            r_prime    <= '0;
            r_mask     <= RESET_MASK;
            r_edge     <= '0;
            r_readdata <= '0;
        end else begin
            r_d1 <= w_data_in;
            if (r_prime != PRIME_DONE) begin
                r_prime <= r_prime + 2'd1;
            end
            if (w_wr && (address == ADDR_MASK)) begin
                r_mask <= w_wdata;
            end
            r_edge     <= w_edge_next;
            // Registered every cycle from pre-update contents; chipselect
            // is not needed for reads.
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_finalprojsoc_keyin.sv
module tb_finalprojsoc_keyin;
    import finalprojsoc_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs0, cs1, write_n;
    logic [31:0] writedata;
    logic [7:0]  in0, in1;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    // dut0: rising-edge capture, mask resets to 0
    finalprojsoc_keyin #(
        .DATA_WIDTH (8),
        .EDGE_TYPE  (EDGE_RISE),
        .RESET_MASK (8'h00)
    ) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs0),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in0),
        .readdata   (rd0),
        .irq        (irq0)
    );

    // dut1: any-edge capture, mask resets to 8'h80
    finalprojsoc_keyin #(
        .DATA_WIDTH (8),
        .EDGE_TYPE  (EDGE_ANY),
        .RESET_MASK (8'h80)
    ) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs1),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in1),
        .readdata   (rd1),
        .irq        (irq1)
    );

    typedef struct {
        bit          sel;
        logic [31:0] rd;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   tb_rd = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Monitor: a read issued at a posedge presents readdata after that edge;
    // compare it (and irq) at the following negedge against the queue head.
    initial begin : monitor
        bit   s;
        exp_t e;
        forever begin
            @(posedge clk);
            s = tb_rd;
            @(negedge clk);
            if (s) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_empty: read seen with no expected entry");
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_rd"}, e.sel ? rd1 : rd0, e.rd);
                    check({e.tag, "_irq"}, {31'b0, (e.sel ? irq1 : irq0)}, {31'b0, e.irq});
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] exp,
                      input logic exp_irq, input string tag);
        exp_t e;
        address = a;
        tb_rd   = 1'b1;
        e.sel   = sel;
        e.rd    = exp;
        e.irq   = exp_irq;
        e.tag   = tag;
        sb.push_back(e);
        tick();
        tb_rd = 1'b0;
    endtask

    task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs0       = ~sel;
        cs1       = sel;
        write_n   = 1'b0;
        tick();
        cs0       = 1'b0;
        cs1       = 1'b0;
        write_n   = 1'b1;
    endtask

    task automatic drain();
        tick();
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected reads outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = ADDR_DATA;
        cs0       = 1'b0;
        cs1       = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        in0       = 8'hA5;
        in1       = 8'h00;
        tick(3);
        check("inrst_rd0", rd0, 32'h0);
        check("inrst_irq0", {31'b0, irq0}, 32'h0);

        reset_n = 1'b1;
        tick(4);
        rd(0, ADDR_DATA, 32'h000000A5, 1'b0, "data_a5");
        rd(0, ADDR_EDGE, 32'h0, 1'b0, "prime_edge");
        rd(0, ADDR_MASK, 32'h0, 1'b0, "mask_rst0");
        rd(1, ADDR_MASK, 32'h80, 1'b0, "mask_rst1");

        // falling edges are ignored by the rising-edge instance
        in0 = 8'h00;
        tick(3);
        rd(0, ADDR_EDGE, 32'h0, 1'b0, "fall_ign");

        wr(0, ADDR_MASK, 32'h1);
        rd(0, ADDR_MASK, 32'h1, 1'b0, "mask_wr");

        // bit0 rises before edge k: captured at edge k+2
        in0 = 8'h01;
        tick(2);
        rd(0, ADDR_EDGE, 32'h0, 1'b1, "rise_lat");
        rd(0, ADDR_EDGE, 32'h1, 1'b1, "rise_cap");
        wr(0, ADDR_EDGE, 32'h1);
        rd(0, ADDR_EDGE, 32'h0, 1'b0, "w1c");

        // masked capture, then unmask
        wr(0, ADDR_MASK, 32'h0);
        in0 = 8'h09;
        tick(3);
        rd(0, ADDR_EDGE, 32'h08, 1'b0, "masked");
        wr(0, ADDR_MASK, 32'h08);
        rd(0, ADDR_EDGE, 32'h08, 1'b1, "unmask");

        // bit2 detect on the same edge as its write-1-to-clear
        in0 = 8'h0D;
        tick(2);
        wr(0, ADDR_EDGE, 32'h4);
        rd(0, ADDR_EDGE, 32'h0C, 1'b1, "set_wins");
        wr(0, ADDR_EDGE, 32'h4);
        rd(0, ADDR_EDGE, 32'h08, 1'b1, "w1c_b2");
        wr(0, ADDR_MASK, 32'h0);
        rd(0, ADDR_EDGE, 32'h08, 1'b0, "mask_keep");
        wr(0, ADDR_DIR, 32'hFF);
        rd(0, ADDR_DIR, 32'h0, 1'b0, "dir0");
        wr(0, ADDR_DATA, 32'hFF);
        rd(0, ADDR_DATA, 32'h0D, 1'b0, "data_ro");

        // any-edge instance: pulse on bit7
        in1 = 8'h80;
        tick(3);
        rd(1, ADDR_EDGE, 32'h80, 1'b1, "any_rise");
        tick(2);
        rd(1, ADDR_EDGE, 32'h80, 1'b1, "any_hold");
        wr(1, ADDR_EDGE, 32'h80);
        rd(1, ADDR_EDGE, 32'h0, 1'b0, "any_clr");
        in1 = 8'h00;
        tick(3);
        rd(1, ADDR_EDGE, 32'h80, 1'b1, "any_fall");
        rd(1, ADDR_DIR, 32'h0, 1'b1, "any_dir");

        // pending irq on dut0 then asynchronous reset mid-cycle
        wr(0, ADDR_MASK, 32'h08);
        rd(0, ADDR_EDGE, 32'h08, 1'b1, "pre_rst");
        drain();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_irq0", {31'b0, irq0}, 32'h0);
        check("arst_rd0", rd0, 32'h0);
        check("arst_irq1", {31'b0, irq1}, 32'h0);
        check("arst_rd1", rd1, 32'h0);
        tick(3);
        reset_n = 1'b1;

        // input 8'h0D already high at release: priming must suppress it
        tick(6);
        rd(0, ADDR_EDGE, 32'h0, 1'b0, "reprime");
        rd(0, ADDR_MASK, 32'h0, 1'b0, "mask_rst0b");
        rd(1, ADDR_MASK, 32'h80, 1'b0, "mask_rst1b");
        rd(0, ADDR_DATA, 32'h0D, 1'b0, "data_after");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
